mod_det_3x3_serial: RTL and testbench

// Sequential 3x3 signed determinant engine for the coprocessor datapath. Receives
// the nine matrix elements as a serial valid/ready stream (row-major a..i), computes
// det = a(ei-fh) - b(di-fg) + c(dh-eg) with one shared multiplier, and returns the

---
 rtl/mod_det_3x3_serial.sv | 184 ++++++++++++++++++
 tb/tb_mod_det_3x3_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_det_3x3_serial.sv
// rtl/mod_det_3x3_serial.sv - serial 3x3 signed determinant engine, one shared multiplier
module mod_det_3x3_serial #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] resultado,
  output logic signed [ACC_W-1:0]  res_full,
  output logic                     ovf,
  output logic                     err,
  output logic                     busy
);

  // Minors are differences of two DATA_W x DATA_W products: 2*DATA_W+1 bits hold them exactly.
  localparam int MW = 2 * DATA_W + 1;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic               [3:0]  r_idx;
  logic               [3:0]  r_step;
  logic signed [DATA_W-1:0]  r_elem [9];
  logic signed [MW-1:0]      r_m0;
  logic signed [MW-1:0]      r_m1;
  logic signed [MW-1:0]      r_m2;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_out_valid;
  logic        [DATA_W-1:0]  r_resultado;
  logic signed [ACC_W-1:0]   r_res_full;
  logic                      r_ovf;
  logic                      r_err;

  logic                      w_xfer;
  logic                      w_last_slot;
  logic                      w_frame_ok;
  logic                      w_frame_err;
  logic signed [DATA_W-1:0]  w_opa;
  logic signed [MW-1:0]      w_opb;
  logic signed [ACC_W-1:0]   w_opa_x;
  logic signed [ACC_W-1:0]   w_opb_x;
  logic signed [ACC_W-1:0]   w_prod;
  logic                      w_ovf;

  function automatic logic signed [MW-1:0] sx(input logic signed [DATA_W-1:0] x);
    return {{(MW-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  assign in_ready    = (r_state == S_LOAD) && !rst;
  assign busy        = (r_state == S_CALC) || (r_state == S_DONE);
  assign out_valid   = r_out_valid;
  assign resultado   = r_resultado;
  assign res_full    = r_res_full;
  assign ovf         = r_ovf;
  assign err         = r_err;

  assign w_xfer      = in_valid && in_ready;
  assign w_last_slot = (r_idx == 4'd8);
  assign w_frame_ok  = w_xfer && w_last_slot && in_last;
  assign w_frame_err = w_xfer && (in_last != w_last_slot);

  // Shared multiplier: both operands sign-extended to ACC_W, low ACC_W bits are exact.
  assign w_opa_x = {{(ACC_W-DATA_W){w_opa[DATA_W-1]}}, w_opa};
  assign w_opb_x = {{(ACC_W-MW){w_opb[MW-1]}}, w_opb};
  assign w_prod  = w_opa_x * w_opb_x;

  // Result overflows the element width when the bits above the sign bit are not all sign copies.
  assign w_ovf = (r_acc[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){r_acc[DATA_W-1]}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  // Next-state: a well-formed frame computes, a misplaced in_last reports straight away.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_frame_ok)       w_next = S_CALC;
        else if (w_frame_err) w_next = S_DONE;
      end
      S_CALC: if (r_step == 4'd9) w_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // Operand select per step (elements a..i are r_elem[0..8]).
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    unique case (r_step)
      4'd0: begin w_opa = r_elem[4]; w_opb = sx(r_elem[8]); end  // e*i
      4'd1: begin w_opa = r_elem[5]; w_opb = sx(r_elem[7]); end  // f*h
      4'd2: begin w_opa = r_elem[3]; w_opb = sx(r_elem[8]); end  // d*i
      4'd3: begin w_opa = r_elem[5]; w_opb = sx(r_elem[6]); end  // f*g
      4'd4: begin w_opa = r_elem[3]; w_opb = sx(r_elem[7]); end  // d*h
      4'd5: begin w_opa = r_elem[4]; w_opb = sx(r_elem[6]); end  // e*g
      4'd6: begin w_opa = r_elem[0]; w_opb = r_m0;          end  // a*m0
      4'd7: begin w_opa = r_elem[1]; w_opb = r_m1;          end  // b*m1
      4'd8: begin w_opa = r_elem[2]; w_opb = r_m2;          end  // c*m2
      default: ;
    endcase
  end

  // Element capture, minor/accumulator sequencing and registered result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_step      <= '0;
      r_m0        <= '0;
      r_m1        <= '0;
      r_m2        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_resultado <= '0;
      r_res_full  <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_elem[r_idx] <= in_data;
            r_idx         <= r_idx + 4'd1;
            if (w_frame_ok) begin
              r_idx  <= '0;
              r_step <= '0;
            end
            if (w_frame_err) begin
              r_idx       <= '0;
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
              r_ovf       <= 1'b0;
              r_resultado <= '0;
              r_res_full  <= '0;
            end
          end
        end
        S_CALC: begin
          r_step <= r_step + 4'd1;
          unique case (r_step)
            4'd0: r_m0  <= w_prod[MW-1:0];
            4'd1: r_m0  <= r_m0 - w_prod[MW-1:0];
            4'd2: r_m1  <= w_prod[MW-1:0];
            4'd3: r_m1  <= r_m1 - w_prod[MW-1:0];
            4'd4: r_m2  <= w_prod[MW-1:0];
            4'd5: r_m2  <= r_m2 - w_prod[MW-1:0];
            4'd6: r_acc <= w_prod;
            4'd7: r_acc <= r_acc - w_prod;
            4'd8: r_acc <= r_acc + w_prod;
            default: begin
              // Extra finalize cycle registers the result fields from the settled accumulator.
              r_step      <= '0;
              r_res_full  <= r_acc;
              r_resultado <= r_acc[DATA_W-1:0];
              r_ovf       <= w_ovf;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
            end
          endcase
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_det_3x3_serial.sv
// tb/tb_mod_det_3x3_serial.sv - scoreboard bench for the serial 3x3 determinant engine
module tb_mod_det_3x3_serial;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic        [7:0]  resultado;
  logic signed [25:0] res_full;
  logic               ovf;
  logic               err;
  logic               busy;

  mod_det_3x3_serial #(.DATA_W(8), .ACC_W(26)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .resultado(resultado), .res_full(res_full), .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int det;
    bit err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  fr [9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pop one expectation per accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t        e;
        logic [31:0] dv;
        longint      exp_ovf;
        e  = sb_q.pop_front();
        dv = e.det;
        exp_ovf = (!e.err && (e.det > 127 || e.det < -128)) ? 1 : 0;
        chk("res_full",  longint'(res_full), longint'(e.det));
        chk("resultado", longint'(resultado), longint'(dv[7:0]));
        chk("ovf",       longint'(ovf), exp_ovf);
        chk("err",       longint'(err), longint'(e.err));
      end
    end
  end

  // Present one element and hold it until the engine takes it; returns at edge+1.
  task automatic push_elem(input logic [7:0] d, input logic last, input bit rnd);
    int guard;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int lastpos, input bit rnd);
    for (int k = 0; k < n; k++) push_elem(fr[k], (k == lastpos), rnd);
  endtask

  task automatic set_fr(input logic [7:0] a, b, c, d, e, f, g, h, i);
    fr[0] = a; fr[1] = b; fr[2] = c;
    fr[3] = d; fr[4] = e; fr[5] = f;
    fr[6] = g; fr[7] = h; fr[8] = i;
  endtask

  task automatic wait_valid(input string name);
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk(name, 0, 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_full", res_full, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // All ones: singular.
    set_fr(1, 1, 1, 1, 1, 1, 1, 1, 1);
    sb_q.push_back('{det: 0, err: 1'b0});
    send_frame(9, 8, 1'b0);

    // Determinant -1.
    set_fr(1, 1, 1, 2, 1, 2, 1, 1, 2);
    sb_q.push_back('{det: -1, err: 1'b0});
    send_frame(9, 8, 1'b0);

    // Negative elements, det 12, with latency measurement.
    set_fr(-1, -4, -7, -2, -3, -8, -1, -2, -7);
    sb_q.push_back('{det: 12, err: 1'b0});
    send_frame(9, 8, 1'b0);
    chk("busy_calc", busy, 1);
    chk("in_ready_calc", in_ready, 0);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 40);
    chk("latency", cnt, 10);

    // Diagonal extremes.
    set_fr(127, 0, 0, 0, 127, 0, 0, 0, 127);
    sb_q.push_back('{det: 2048383, err: 1'b0});
    send_frame(9, 8, 1'b0);
    set_fr(8'h80, 0, 0, 0, 8'h80, 0, 0, 0, 8'h80);
    sb_q.push_back('{det: -2097152, err: 1'b0});
    send_frame(9, 8, 1'b0);

    // Misplaced in_last on the 5th element, result held under back-pressure.
    set_fr(3, 5, 7, 9, 11, 0, 0, 0, 0);
    wait_valid("drain_timeout");
    @(posedge clk); #1;
    out_ready = 1'b0;
    sb_q.push_back('{det: 0, err: 1'b1});
    send_frame(5, 4, 1'b0);
    wait_valid("err_valid_timeout");
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_err", err, 1);
      chk("hold_res_full", res_full, 0);
      chk("hold_resultado", resultado, 0);
      chk("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drop_valid", out_valid, 0);
    chk("drop_err", err, 0);
    chk("after_err_in_ready", in_ready, 1);

    // Next frame after the error computes normally.
    set_fr(1, 1, 1, 2, 1, 2, 1, 1, 2);
    sb_q.push_back('{det: -1, err: 1'b0});
    send_frame(9, 8, 1'b0);

    // Partial frame aborted by reset.
    set_fr(9, 9, 9, 9, 9, 9, 9, 9, 9);
    send_frame(4, 99, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_res_full", res_full, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);

    // Fresh frame with gappy in_valid.
    set_fr(-1, -4, -7, -2, -3, -8, -1, -2, -7);
    sb_q.push_back('{det: 12, err: 1'b0});
    send_frame(9, 8, 1'b1);

    cnt = 0;
    while (sb_q.size() != 0 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
